// File: rtl/rx_fifo.sv
// ============================================================================
// Module   : rx_fifo
// Purpose  : Receive-side FWFT byte buffer (I2C receiver -> 3DES/register
//            logic) with occupancy flags and overrun detection.
//            Optional macro RX_FIFO_COUNT_PORT_EN exposes the occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    write_enable,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic                    read_enable,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    fifo_empty,
    output logic                    fifo_full,
    output logic                    almost_full,
    output logic                    overrun,
    output logic                    overrun_flag,
`ifdef RX_FIFO_COUNT_PORT_EN
    output logic [$clog2(DEPTH):0]  fifo_count,
`endif
    input  logic                    clear_overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF_LEVEL = CW'(AF_LEVEL);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("rx_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_almost_full;
    logic                  r_overrun;
    logic                  r_overrun_flag;

    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_drop;
    logic [CW-1:0]         w_count_nxt;

    // Flush swallows any same-cycle read or write, including overrun detection.
    assign w_rd_acc = read_enable & ~r_empty & ~flush;
    assign w_wr_acc = write_enable & (~r_full | w_rd_acc) & ~flush;
    assign w_drop   = write_enable & r_full & ~w_rd_acc & ~flush;

    always_comb begin
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = '0;
        end else begin
            w_count_nxt = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_full  <= 1'b0;
            r_overrun      <= 1'b0;
            r_overrun_flag <= 1'b0;
        end else begin
            if (flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                r_wptr <= r_wptr + AW'(w_wr_acc);
                r_rptr <= r_rptr + AW'(w_rd_acc);
            end
            r_count       <= w_count_nxt;
            r_empty       <= (w_count_nxt == '0);
            r_full        <= (w_count_nxt == C_DEPTH);
            r_almost_full <= (w_count_nxt >= C_AF_LEVEL);
            r_overrun     <= w_drop;
            if (w_drop) begin
                r_overrun_flag <= 1'b1;
            end else if (clear_overrun) begin
                r_overrun_flag <= 1'b0;
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wptr] <= write_data;
        end
    end

    // Head is masked while empty so read_data is a clean 0 after reset.
    assign read_data    = r_empty ? '0 : r_mem[r_rptr];
    assign fifo_empty   = r_empty;
    assign fifo_full    = r_full;
    assign almost_full  = r_almost_full;
    assign overrun      = r_overrun;
    assign overrun_flag = r_overrun_flag;
`ifdef RX_FIFO_COUNT_PORT_EN
    assign fifo_count   = r_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rx_fifo.sv
// ============================================================================
// Module   : tb_rx_fifo
// Purpose  : Self-checking bench for rx_fifo: vector table, directed corner
//            sequences and randomized traffic against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rx_fifo;

    localparam int DW = 8;
    localparam int DP = 8;
    localparam int AF = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          write_enable = 1'b0;
    logic [DW-1:0] write_data = '0;
    logic          read_enable = 1'b0;
    logic [DW-1:0] read_data;
    logic          fifo_empty;
    logic          fifo_full;
    logic          almost_full;
    logic          overrun;
    logic          overrun_flag;
    logic          clear_overrun = 1'b0;
`ifdef RX_FIFO_COUNT_PORT_EN
    logic [$clog2(DP):0] fifo_count;
`endif

    rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DP), .AF_LEVEL(AF)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .write_enable  (write_enable),
        .write_data    (write_data),
        .read_enable   (read_enable),
        .read_data     (read_data),
        .fifo_empty    (fifo_empty),
        .fifo_full     (fifo_full),
        .almost_full   (almost_full),
        .overrun       (overrun),
        .overrun_flag  (overrun_flag),
`ifdef RX_FIFO_COUNT_PORT_EN
        .fifo_count    (fifo_count),
`endif
        .clear_overrun (clear_overrun)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: occupancy is just the queue size.
    logic [DW-1:0] m_q [$];
    logic          m_flag = 1'b0;
    logic          m_ovr  = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_update(input logic we, input logic [DW-1:0] wd, input logic re,
                                input logic fl, input logic co, input logic rs);
        bit rd, wr, drop;
        if (rs) begin
            m_q.delete();
            m_flag = 1'b0;
            m_ovr  = 1'b0;
        end else if (fl) begin
            m_q.delete();
            m_ovr = 1'b0;
            if (co) m_flag = 1'b0;
        end else begin
            rd   = re && (m_q.size() > 0);
            wr   = we && ((m_q.size() < DP) || rd);
            drop = we && (m_q.size() == DP) && !rd;
            if (rd) void'(m_q.pop_front());
            if (wr) m_q.push_back(wd);
            m_ovr = drop;
            if (drop) m_flag = 1'b1;
            else if (co) m_flag = 1'b0;
        end
    endtask

    task automatic check_model(input string tag);
        logic [DW-1:0] exp_rd;
        exp_rd = (m_q.size() > 0) ? m_q[0] : '0;
        chk({tag, ".empty"}, 32'(fifo_empty),   32'(m_q.size() == 0));
        chk({tag, ".full"},  32'(fifo_full),    32'(m_q.size() == DP));
        chk({tag, ".af"},    32'(almost_full),  32'(m_q.size() >= AF));
        chk({tag, ".ovr"},   32'(overrun),      32'(m_ovr));
        chk({tag, ".flag"},  32'(overrun_flag), 32'(m_flag));
        chk({tag, ".rdata"}, 32'(read_data),    32'(exp_rd));
`ifdef RX_FIFO_COUNT_PORT_EN
        chk({tag, ".count"}, 32'(fifo_count),   32'(m_q.size()));
`endif
    endtask

    // Drive one cycle of inputs, advance past the edge, compare with the model.
    task automatic step(input string tag, input logic we, input logic [DW-1:0] wd,
                        input logic re, input logic fl, input logic co, input logic rs);
        write_enable  = we;
        write_data    = wd;
        read_enable   = re;
        flush         = fl;
        clear_overrun = co;
        rst           = rs;
        @(posedge clk);
        model_update(we, wd, re, fl, co, rs);
        #1;
        write_enable  = 1'b0;
        read_enable   = 1'b0;
        flush         = 1'b0;
        clear_overrun = 1'b0;
        rst           = 1'b0;
        check_model(tag);
    endtask

    typedef struct {
        logic          we;
        logic [DW-1:0] wd;
        logic          re;
        logic          e_empty;
        logic          e_full;
        logic [DW-1:0] e_rd;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // we, wd, re, expected empty/full/read_data after the edge
        vecs[0] = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 8'hA1};
        vecs[1] = '{1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 8'hA1};
        vecs[2] = '{1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 8'hA1};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hB2};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hC3};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[7] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};

        // Reset then idle
        @(negedge clk);
        step("rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        step("idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.empty", 32'(fifo_empty), 32'd1);
        chk("reset.full",  32'(fifo_full),  32'd0);
        chk("reset.af",    32'(almost_full), 32'd0);
        chk("reset.flag",  32'(overrun_flag), 32'd0);
        chk("reset.rdata", 32'(read_data), 32'd0);

        // Vector table: ordered write/read, read-while-empty, empty R+W
        for (int i = 0; i < 9; i++) begin
            step($sformatf("vec%0d", i), vecs[i].we, vecs[i].wd, vecs[i].re, 1'b0, 1'b0, 1'b0);
            chk($sformatf("vec%0d.tbl_empty", i), 32'(fifo_empty), 32'(vecs[i].e_empty));
            chk($sformatf("vec%0d.tbl_full", i),  32'(fifo_full),  32'(vecs[i].e_full));
            chk($sformatf("vec%0d.tbl_rdata", i), 32'(read_data),  32'(vecs[i].e_rd));
        end

        // Fill to full, then overrun
        for (int i = 0; i < DP; i++) begin
            step($sformatf("fill%0d", i), 1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == AF - 1) chk("fill.af_at_6", 32'(almost_full), 32'd1);
            if (i == AF - 2) chk("fill.af_at_5", 32'(almost_full), 32'd0);
        end
        chk("fill.full", 32'(fifo_full), 32'd1);
        step("ovr_wr", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr.pulse", 32'(overrun), 32'd1);
        chk("ovr.flag",  32'(overrun_flag), 32'd1);
        step("ovr_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr.pulse_gone", 32'(overrun), 32'd0);
        chk("ovr.flag_sticky", 32'(overrun_flag), 32'd1);
        for (int i = 0; i < DP; i++) begin
            chk($sformatf("drain.head%0d", i), 32'(read_data), 32'(i));
            step($sformatf("drain%0d", i), 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        chk("drain.empty", 32'(fifo_empty), 32'd1);

        // Full buffer, simultaneous read/write; 16 rounds wrap the pointers
        for (int i = 0; i < DP; i++)
            step($sformatf("refill%0d", i), 1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step($sformatf("rwfull%0d", i), 1'b1, (i == 0) ? 8'h55 : 8'(8'h60 + i),
                 1'b1, 1'b0, 1'b0, 1'b0);
            chk($sformatf("rwfull%0d.no_ovr", i), 32'(overrun), 32'd0);
            chk($sformatf("rwfull%0d.full", i), 32'(fifo_full), 32'd1);
        end
        for (int i = 0; i < DP; i++)
            step($sformatf("rwdrain%0d", i), 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        // Clear flag, then clear and a dropped write together: set wins
        step("clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("clr.flag", 32'(overrun_flag), 32'd0);
        for (int i = 0; i < DP; i++)
            step($sformatf("fill2_%0d", i), 1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        step("set_vs_clr", 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("set_vs_clr.flag", 32'(overrun_flag), 32'd1);

        // Flush with 4 stored plus a same-cycle write
        step("pre_flush_rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        step("set_again0", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            step($sformatf("f4_%0d", i), 1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        step("flush", 1'b1, 8'h99, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("flush.empty", 32'(fifo_empty), 32'd1);
        chk("flush.rdata", 32'(read_data), 32'd0);
        step("flush_idle", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("flush.not_stored", 32'(fifo_empty), 32'd1);

        // Flag survives flush
        for (int i = 0; i < DP + 1; i++)
            step($sformatf("f9_%0d", i), 1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        step("flush2", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("flush2.flag_kept", 32'(overrun_flag), 32'd1);

        // Reset with 5 stored
        for (int i = 0; i < 5; i++)
            step($sformatf("r5_%0d", i), 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        step("rst5", 1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("rst5.empty", 32'(fifo_empty), 32'd1);
        chk("rst5.flag", 32'(overrun_flag), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step("rand",
                 ($urandom_range(0, 99) < 55),
                 8'($urandom),
                 ($urandom_range(0, 99) < 45),
                 ($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 5),
                 ($urandom_range(0, 499) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
